spi_slave_frame_rx: RTL and testbench

Parametrised SPI slave front end in the `clk_12mhz` domain. It replaces the fixed 8-bit, mode-0, two-byte command decode behind the `spi_clk`/`spi_mosi`/`spi_cs`/`spi_miso` pins of `top`. It oversamples the SPI pins and supports all four CPOL/CPHA modes, configurable word width and frames of up to `MAX_WORDS` words. It delivers each received word with an index and returns one transmit word per received word on `spi_miso`.

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_sync_edge.sv | 36 +++
 rtl/spi_slave_frame_rx.sv | 176 +++++++++++++++++
 tb/tb_spi_slave_frame_rx.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI slave types, mode encodings and helpers.
// Imported by the synchroniser and the frame receiver.
package spi_pkg;

    // {CPOL, CPHA} pairs
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } spi_rx_state_t;

    // 1: data is sampled on the rising spi_clk edge, 0: on the falling edge
    function automatic logic sample_on_rise(input logic cpol, input logic cpha);
        return cpol == cpha;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchroniser for one asynchronous pin with registered edge strobes.
// Ports: clk, rst (async active-low), d (pin), level (synced), rise/fall (1-cycle strobes).
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter int   N       = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [N-1:0] sync_q;
    logic         dly_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= {N{RST_VAL}};
            dly_q  <= RST_VAL;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[N-2:0], d};
            dly_q  <= sync_q[N-1];
            rise   <= sync_q[N-1] & ~dly_q;
            fall   <= ~sync_q[N-1] & dly_q;
        end
    end

    assign level = sync_q[N-1];

endmodule

// File: rtl/spi_slave_frame_rx.sv
// Oversampled SPI slave: any CPOL/CPHA, WORD_BITS words, up to MAX_WORDS per CS frame.
// Ports: clk_12mhz, rst (async active-low), spi_clk/spi_cs/spi_mosi pins, spi_miso,
// tx_word/tx_load reply handshake, rx_word/rx_index/rx_valid, frame_done/frame_len,
// overrun_err (sticky per frame), short_err (trailing partial word at frame end).
module spi_slave_frame_rx
    import spi_pkg::*;
#(
    parameter int   WORD_BITS   = 8,
    parameter int   MAX_WORDS   = 4,
    parameter logic CPOL        = 1'b0,
    parameter logic CPHA        = 1'b0,
    parameter int   SYNC_STAGES = 2,
    parameter int   IW          = $clog2(MAX_WORDS + 1)
) (
    input  logic                 clk_12mhz,
    input  logic                 rst,
    input  logic                 spi_clk,
    input  logic                 spi_cs,
    input  logic                 spi_mosi,
    output logic                 spi_miso,
    input  logic [WORD_BITS-1:0] tx_word,
    output logic                 tx_load,
    output logic [WORD_BITS-1:0] rx_word,
    output logic [IW-1:0]        rx_index,
    output logic                 rx_valid,
    output logic                 frame_done,
    output logic [IW-1:0]        frame_len,
    output logic                 overrun_err,
    output logic                 short_err
);

    localparam int              BW          = $clog2(WORD_BITS + 1);
    localparam logic            SAMPLE_RISE = sample_on_rise(CPOL, CPHA);
    localparam logic [BW-1:0]   BITS_FULL   = BW'(WORD_BITS);
    localparam logic [IW-1:0]   WORDS_MAX   = IW'(MAX_WORDS);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;

    spi_sync_edge #(.N(SYNC_STAGES), .RST_VAL(CPOL)) u_sync_clk (
        .clk   (clk_12mhz),
        .rst   (rst),
        .d     (spi_clk),
        .level (sclk_lvl),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    spi_sync_edge #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk   (clk_12mhz),
        .rst   (rst),
        .d     (spi_cs),
        .level (cs_lvl),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    spi_sync_edge #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk   (clk_12mhz),
        .rst   (rst),
        .d     (spi_mosi),
        .level (mosi_lvl),
        .rise  (mosi_rise),
        .fall  (mosi_fall)
    );

    logic sample_stb;
    logic shift_stb;

    assign sample_stb = SAMPLE_RISE ? sclk_rise : sclk_fall;
    assign shift_stb  = SAMPLE_RISE ? sclk_fall : sclk_rise;

    spi_rx_state_t         state;
    logic [BW-1:0]         bit_cnt;
    logic [IW-1:0]         word_cnt;
    logic [WORD_BITS-1:0]  rx_sr;
    logic [WORD_BITS-1:0]  tx_sr;
    logic                  tx_shift_q;
    logic                  cs_end_q;

    logic word_done;
    logic wc_inc;

    assign word_done = (bit_cnt == BITS_FULL);
    assign wc_inc    = word_done && (word_cnt < WORDS_MAX);

    // Edge decisions are taken one cycle after the strobe; their effect on
    // rx_valid, spi_miso and frame_done lands one cycle after that.
    always_ff @(posedge clk_12mhz or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            word_cnt    <= '0;
            rx_sr       <= '0;
            tx_sr       <= '0;
            tx_shift_q  <= 1'b0;
            cs_end_q    <= 1'b0;
            spi_miso    <= 1'b0;
            tx_load     <= 1'b0;
            rx_word     <= '0;
            rx_index    <= '0;
            rx_valid    <= 1'b0;
            frame_done  <= 1'b0;
            frame_len   <= '0;
            overrun_err <= 1'b0;
            short_err   <= 1'b0;
        end else begin
            tx_load    <= 1'b0;
            tx_shift_q <= 1'b0;
            cs_end_q   <= 1'b0;
            rx_valid   <= 1'b0;
            frame_done <= 1'b0;

            // tx_word is taken while tx_load is high
            if (tx_load) begin
                tx_sr    <= tx_word;
                spi_miso <= tx_word[WORD_BITS-1];
            end else if (tx_shift_q) begin
                tx_sr    <= {tx_sr[WORD_BITS-2:0], 1'b0};
                spi_miso <= tx_sr[WORD_BITS-2];
            end

            if (word_done) begin
                bit_cnt <= '0;
                if (wc_inc) begin
                    rx_word  <= rx_sr;
                    rx_index <= word_cnt;
                    rx_valid <= 1'b1;
                    word_cnt <= word_cnt + IW'(1);
                end else begin
                    overrun_err <= 1'b1;
                end
            end

            unique case (state)
                IDLE: begin
                    if (cs_fall) begin
                        tx_load     <= 1'b1;
                        bit_cnt     <= '0;
                        word_cnt    <= '0;
                        overrun_err <= 1'b0;
                        state       <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cs_end_q) begin
                        frame_done <= 1'b1;
                        frame_len  <= word_cnt + IW'(wc_inc);
                        short_err  <= (bit_cnt != '0) && !word_done;
                        bit_cnt    <= '0;
                        spi_miso   <= 1'b0;
                        state      <= IDLE;
                    end else if (cs_rise) begin
                        // CS wins over a coincident clock edge
                        cs_end_q <= 1'b1;
                    end else if (sample_stb) begin
                        rx_sr   <= {rx_sr[WORD_BITS-2:0], mosi_lvl};
                        bit_cnt <= word_done ? BW'(1) : bit_cnt + BW'(1);
                    end else if (shift_stb) begin
                        // bit_cnt==0 on a shift edge: word boundary, fetch next reply
                        if (bit_cnt == '0) begin
                            tx_load <= 1'b1;
                        end else begin
                            tx_shift_q <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    logic unused_ok;
    assign unused_ok = ^{sclk_lvl, cs_lvl, mosi_rise, mosi_fall, tx_sr[WORD_BITS-1]};

endmodule

// File: tb/tb_spi_slave_frame_rx.sv
// Directed bench for spi_slave_frame_rx: four 8-bit mode instances plus a 16-bit instance.
// All expectations are hand-computed constants.
module tb_spi_slave_frame_rx;

    localparam int H    = 8;
    localparam int SYNC = 2;

    logic clk_12mhz = 1'b0;
    logic rst = 1'b0;

    logic        sck  [5];
    logic        cs   [5];
    logic        mosi [5];
    logic        miso [5];
    logic        txl  [5];
    logic        rxv  [5];
    logic        fdn  [5];
    logic        ovr  [5];
    logic        shrt [5];
    logic [2:0]  rxi  [5];
    logic [2:0]  flen [5];
    logic [15:0] rxw  [5];
    logic [7:0]  txw8 [4];
    logic [7:0]  rxw8 [4];
    logic [15:0] txw16;
    logic [15:0] rxw16;
    logic [15:0] reps [8];

    int checks = 0;
    int errors = 0;

    int          rxv_cnt  [5];
    int          fd_cnt   [5];
    int          txl_cnt  [5];
    logic [15:0] log_w    [5][16];
    logic [2:0]  log_i    [5][16];
    logic [2:0]  fd_len   [5];
    logic        fd_short [5];

    always #5 clk_12mhz = ~clk_12mhz;

    for (genvar g = 0; g < 4; g++) begin : g_mode
        spi_slave_frame_rx #(
            .WORD_BITS   (8),
            .MAX_WORDS   (4),
            .CPOL        (g >= 2),
            .CPHA        (g % 2 == 1),
            .SYNC_STAGES (SYNC)
        ) u_dut (
            .clk_12mhz   (clk_12mhz),
            .rst         (rst),
            .spi_clk     (sck[g]),
            .spi_cs      (cs[g]),
            .spi_mosi    (mosi[g]),
            .spi_miso    (miso[g]),
            .tx_word     (txw8[g]),
            .tx_load     (txl[g]),
            .rx_word     (rxw8[g]),
            .rx_index    (rxi[g]),
            .rx_valid    (rxv[g]),
            .frame_done  (fdn[g]),
            .frame_len   (flen[g]),
            .overrun_err (ovr[g]),
            .short_err   (shrt[g])
        );
        assign rxw[g] = {8'h00, rxw8[g]};
    end

    spi_slave_frame_rx #(
        .WORD_BITS   (16),
        .MAX_WORDS   (4),
        .CPOL        (1'b0),
        .CPHA        (1'b0),
        .SYNC_STAGES (SYNC)
    ) u_dut16 (
        .clk_12mhz   (clk_12mhz),
        .rst         (rst),
        .spi_clk     (sck[4]),
        .spi_cs      (cs[4]),
        .spi_mosi    (mosi[4]),
        .spi_miso    (miso[4]),
        .tx_word     (txw16),
        .tx_load     (txl[4]),
        .rx_word     (rxw16),
        .rx_index    (rxi[4]),
        .rx_valid    (rxv[4]),
        .frame_done  (fdn[4]),
        .frame_len   (flen[4]),
        .overrun_err (ovr[4]),
        .short_err   (shrt[4])
    );
    assign rxw[4] = rxw16;

    always @(negedge clk_12mhz) begin
        for (int i = 0; i < 5; i++) begin
            if (rxv[i] === 1'b1) begin
                log_w[i][rxv_cnt[i] % 16] <= rxw[i];
                log_i[i][rxv_cnt[i] % 16] <= rxi[i];
                rxv_cnt[i] <= rxv_cnt[i] + 1;
            end
            if (fdn[i] === 1'b1) begin
                fd_len[i]   <= flen[i];
                fd_short[i] <= shrt[i];
                fd_cnt[i]   <= fd_cnt[i] + 1;
            end
            if (txl[i] === 1'b1) begin
                txl_cnt[i] <= txl_cnt[i] + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tx_set(input int d, input logic [15:0] v);
        if (d < 4) txw8[d] = v[7:0];
        else txw16 = v;
    endtask

    // Master side of one CS frame; cap collects MISO bits MSB first,
    // lat = negedges from the last sample edge until rx_valid is seen.
    task automatic spi_xfer(input int d, input logic cpol, input logic cpha,
                            input int nbits, input logic [79:0] bits,
                            input logic raise_cs,
                            output logic [79:0] cap, output int lat);
        int w;
        w = (d == 4) ? 16 : 8;
        cap = '0;
        lat = 0;
        sck[d] = cpol;
        tx_set(d, reps[0]);
        cs[d] = 1'b0;
        if (cpha) repeat (H) @(negedge clk_12mhz);
        for (int b = 0; b < nbits; b++) begin
            if (!cpha) begin
                mosi[d] = bits[nbits-1-b];
                repeat (H) @(negedge clk_12mhz);
                cap = {cap[78:0], miso[d]};
                sck[d] = ~cpol;
            end else begin
                sck[d] = ~cpol;
                mosi[d] = bits[nbits-1-b];
                repeat (H) @(negedge clk_12mhz);
                cap = {cap[78:0], miso[d]};
                sck[d] = cpol;
            end
            if ((b % w) == w - 1) tx_set(d, reps[b / w + 1]);
            for (int k = 1; k <= H; k++) begin
                @(negedge clk_12mhz);
                if (b == nbits - 1 && lat == 0 && rxv[d] === 1'b1) lat = k;
            end
            if (!cpha) sck[d] = cpol;
        end
        repeat (H) @(negedge clk_12mhz);
        if (raise_cs) begin
            cs[d] = 1'b1;
            mosi[d] = 1'b0;
            repeat (3 * H) @(negedge clk_12mhz);
        end
    endtask

    initial begin
        int b0;
        int f0;
        int t0;
        int lat;
        logic [79:0] cap;

        for (int i = 0; i < 5; i++) begin
            sck[i]  = (i == 2 || i == 3);
            cs[i]   = 1'b1;
            mosi[i] = 1'b0;
        end
        for (int i = 0; i < 4; i++) txw8[i] = 8'h00;
        for (int i = 0; i < 8; i++) reps[i] = 16'h0000;
        txw16 = 16'h0000;

        repeat (3) @(negedge clk_12mhz);
        chk("reset_dut0", {miso[0], txl[0], rxv[0], fdn[0], ovr[0], shrt[0],
                           flen[0], rxi[0], rxw[0]}, 32'h0);
        chk("reset_dut3", {miso[3], txl[3], rxv[3], fdn[3], ovr[3], shrt[3],
                           flen[3], rxi[3], rxw[3]}, 32'h0);
        chk("reset_dut16", {miso[4], txl[4], rxv[4], fdn[4], ovr[4], shrt[4],
                            flen[4], rxi[4], rxw[4]}, 32'h0);
        rst = 1'b1;
        repeat (5) @(negedge clk_12mhz);

        // Same 2-word frame in all four modes
        for (int m = 0; m < 4; m++) begin
            b0 = rxv_cnt[m];
            f0 = fd_cnt[m];
            t0 = txl_cnt[m];
            reps[0] = 16'h00A5;
            reps[1] = 16'h003C;
            reps[2] = 16'h0000;
            spi_xfer(m, m >= 2, m % 2 == 1, 16, 80'h0401, 1'b1, cap, lat);
            chk($sformatf("m%0d_rx_count", m), rxv_cnt[m] - b0, 2);
            chk($sformatf("m%0d_word0", m), log_w[m][b0 % 16], 16'h0004);
            chk($sformatf("m%0d_idx0", m), log_i[m][b0 % 16], 0);
            chk($sformatf("m%0d_word1", m), log_w[m][(b0 + 1) % 16], 16'h0001);
            chk($sformatf("m%0d_idx1", m), log_i[m][(b0 + 1) % 16], 1);
            chk($sformatf("m%0d_miso_bits", m), cap[15:0], 16'hA53C);
            chk($sformatf("m%0d_fd_count", m), fd_cnt[m] - f0, 1);
            chk($sformatf("m%0d_frame_len", m), fd_len[m], 2);
            chk($sformatf("m%0d_short", m), fd_short[m], 0);
            chk($sformatf("m%0d_tx_loads", m), txl_cnt[m] - t0, 3);
            chk($sformatf("m%0d_miso_idle", m), miso[m], 0);
        end

        // Five words into a four-word frame
        b0 = rxv_cnt[0];
        for (int i = 0; i < 6; i++) reps[i] = 16'(i + 1);
        spi_xfer(0, 1'b0, 1'b0, 40, 80'h1122334455, 1'b1, cap, lat);
        chk("ovr_rx_count", rxv_cnt[0] - b0, 4);
        chk("ovr_last_word", log_w[0][(b0 + 3) % 16], 16'h0044);
        chk("ovr_last_idx", log_i[0][(b0 + 3) % 16], 3);
        chk("ovr_flag", ovr[0], 1);
        chk("ovr_frame_len", fd_len[0], 4);
        chk("ovr_short", fd_short[0], 0);
        cs[0] = 1'b0;
        repeat (H) @(negedge clk_12mhz);
        chk("ovr_cleared", ovr[0], 0);
        cs[0] = 1'b1;
        repeat (3 * H) @(negedge clk_12mhz);

        // CS rise after 11 bits: one word plus 3 discarded bits
        b0 = rxv_cnt[0];
        f0 = fd_cnt[0];
        spi_xfer(0, 1'b0, 1'b0, 11, 80'h61D, 1'b1, cap, lat);
        chk("short_rx_count", rxv_cnt[0] - b0, 1);
        chk("short_word", log_w[0][b0 % 16], 16'h00C3);
        chk("short_fd_count", fd_cnt[0] - f0, 1);
        chk("short_frame_len", fd_len[0], 1);
        chk("short_flag", fd_short[0], 1);

        // Reset in the middle of a word
        reps[0] = 16'h00A5;
        spi_xfer(0, 1'b0, 1'b0, 5, 80'h16, 1'b0, cap, lat);
        rst = 1'b0;
        #1;
        chk("midrst_outputs", {miso[0], txl[0], rxv[0], fdn[0], ovr[0], shrt[0],
                               flen[0], rxi[0], rxw[0]}, 32'h0);
        @(negedge clk_12mhz);
        cs[0] = 1'b1;
        sck[0] = 1'b0;
        mosi[0] = 1'b0;
        repeat (3) @(negedge clk_12mhz);
        rst = 1'b1;
        repeat (5) @(negedge clk_12mhz);
        b0 = rxv_cnt[0];
        reps[0] = 16'h0081;
        reps[1] = 16'h007E;
        reps[2] = 16'h0000;
        spi_xfer(0, 1'b0, 1'b0, 16, 80'h5A96, 1'b1, cap, lat);
        chk("postrst_rx_count", rxv_cnt[0] - b0, 2);
        chk("postrst_word0", log_w[0][b0 % 16], 16'h005A);
        chk("postrst_word1", log_w[0][(b0 + 1) % 16], 16'h0096);
        chk("postrst_idx1", log_i[0][(b0 + 1) % 16], 1);
        chk("postrst_miso_bits", cap[15:0], 16'h817E);
        chk("postrst_frame_len", fd_len[0], 2);

        // 16-bit word and rx_valid latency. The last sample edge is driven
        // at a negedge; capture is the next posedge, rx_valid rises
        // SYNC+2 posedges later and is first seen on the following negedge.
        b0 = rxv_cnt[4];
        reps[0] = 16'h1234;
        reps[1] = 16'h0000;
        spi_xfer(4, 1'b0, 1'b0, 16, 80'hBEEF, 1'b1, cap, lat);
        chk("w16_rx_count", rxv_cnt[4] - b0, 1);
        chk("w16_word", log_w[4][b0 % 16], 16'hBEEF);
        chk("w16_idx", log_i[4][b0 % 16], 0);
        chk("w16_latency", lat, SYNC + 3);
        chk("w16_miso_bits", cap[15:0], 16'h1234);
        chk("w16_frame_len", fd_len[4], 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
